pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, giving the payload width (PC4, PC and Inst concatenated, 3x32).
REQ-002 The block SHALL have parameter BUBBLE, default {DATA_W{1'b0}}, giving the payload value presented when the stage holds no valid entry.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on the falling edge of Clk.
REQ-004 The block SHALL have port Rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port I_Valid, input, 1 bit: the upstream stage offers I_Data.
REQ-006 The block SHALL have port I_Ready, output, 1 bit: the stage will accept I_Data at the next falling edge.
REQ-007 The block SHALL have port I_Data, input, DATA_W bits: the payload from the upstream stage.
REQ-008 The block SHALL have port Flush, input, 1 bit: a synchronous kill of all held entries (branch/jump redirect).
REQ-009 The block SHALL have port O_Valid, output, 1 bit: O_Data holds a valid entry.
REQ-010 The block SHALL have port O_Ready, input, 1 bit: the downstream stage consumes O_Data at the next falling edge (O_Ready low = stall).
REQ-011 The block SHALL have port O_Data, output, DATA_W bits: the payload to the downstream stage.
REQ-012 The block SHALL have port Count, output, 2 bits: the number of held entries, 0..2.

Function
REQ-013 Storage SHALL be two registered entries: main (drives O_Data/O_Valid) and skid; all outputs SHALL come directly from registers.
REQ-014 Accept SHALL be I_Valid && I_Ready; consume SHALL be O_Valid && O_Ready; both are evaluated at each falling edge of Clk.
REQ-015 I_Ready SHALL equal NOT skid_valid, so it depends only on state and never on O_Ready combinationally.
REQ-016 The state SHALL be one of EMPTY (Count=0), ONE (main valid, Count=1) or FULL (main and skid valid, Count=2).
REQ-017 In EMPTY with accept, main SHALL load I_Data, and the stage SHALL go to ONE; this is 1 edge of latency.
REQ-018 In ONE with accept and consume, main SHALL load I_Data, and the stage SHALL stay in ONE.
REQ-019 In ONE with accept and no consume, skid SHALL load I_Data, the stage SHALL go to FULL, and main SHALL be unchanged.
REQ-020 In ONE with consume and no accept, main SHALL load BUBBLE, and the stage SHALL go to EMPTY.
REQ-021 In ONE with neither accept nor consume, all state SHALL hold.
REQ-022 In FULL with consume, main SHALL load skid, skid SHALL clear, and the stage SHALL go to ONE; no accept is possible in FULL.
REQ-023 In FULL with no consume, all state SHALL hold.
REQ-024 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or lost except by Flush or reset.
REQ-025 Flush high at an edge SHALL override every other event: the stage SHALL go to EMPTY, main and skid SHALL load BUBBLE, and any simultaneous accept or consume is discarded.
REQ-026 When O_Valid is 0, O_Data SHALL equal BUBBLE.
REQ-027 Count SHALL equal main_valid + skid_valid at all times.

Reset
REQ-028 While Rst_n is 0, independent of Clk, the outputs SHALL be O_Valid=0, O_Data=BUBBLE, Count=0 and I_Ready=1, with skid cleared to BUBBLE.
REQ-029 Reset asserted mid-transfer SHALL discard all entries, and the first accept after release SHALL behave as from EMPTY.
REQ-030 On reset release, the first state update SHALL occur on the first falling edge of Clk at which Rst_n is 1.

Verification
REQ-031 Stream test: with O_Ready=1 and I_Valid=1, present payloads A1..A5 on consecutive edges -> O_Data=A1..A5 on consecutive cycles, each one edge after acceptance, with I_Ready constantly 1 and Count constantly 1.
REQ-032 Stall test: with ONE holding A1, drive O_Ready=0 and offer A2 -> Count=2 and I_Ready=0; the bench holds A3 while I_Ready=0; on releasing O_Ready, O_Data=A2 on the next edge, then A3.
REQ-033 Flush test: with FULL (A1, A2), assert Flush together with I_Valid=1 (A3) and O_Ready=1 -> next edge O_Valid=0, O_Data=0, Count=0 and I_Ready=1, and A3 never appears on O_Data.
REQ-034 Reset test: with FULL, pull Rst_n low between edges -> outputs go to reset values immediately, without a clock edge; after release, accept A9 -> O_Data=A9 one edge later.
REQ-035 Drain test: with ONE holding A1, O_Ready=1 and I_Valid=0 -> next edge O_Valid=0, O_Data=BUBBLE and Count=0.
REQ-036 Random test: apply random I_Valid, O_Ready and Flush (5%) for 10k cycles -> the output sequence matches a reference queue model, and Count never exceeds 2.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid buffer pipeline stage clocked on the falling edge.
// I_Ready depends only on skid occupancy, so the stage breaks the combinational ready path.
module pipe_stage_skid #(
    parameter int DATA_W = 96,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              I_Valid,
    output logic              I_Ready,
    input  logic [DATA_W-1:0] I_Data,
    input  logic              Flush,
    output logic              O_Valid,
    input  logic              O_Ready,
    output logic [DATA_W-1:0] O_Data,
    output logic [1:0]        Count
);
    // The encoding equals the number of held entries, so Count is the state register itself.
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state, state_nxt;
    logic [DATA_W-1:0] main_data, main_nxt, skid_data, skid_nxt;
    logic accept, consume;
    assign O_Valid = state != EMPTY;
    assign I_Ready = state != FULL;
    assign O_Data  = main_data;
    assign Count   = state;
    assign accept  = I_Valid && I_Ready;
    assign consume = O_Valid && O_Ready;
    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= EMPTY;
            main_data <= BUBBLE;
            skid_data <= BUBBLE;
        end else begin
            state     <= state_nxt;
            main_data <= main_nxt;
            skid_data <= skid_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        main_nxt  = main_data;
        skid_nxt  = skid_data;
        if (Flush) begin
            state_nxt = EMPTY;
            main_nxt  = BUBBLE;
            skid_nxt  = BUBBLE;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    main_nxt  = I_Data;
                    state_nxt = ONE;
                end
                ONE: if (accept && consume) begin
                    main_nxt = I_Data;
                end else if (accept) begin
                    skid_nxt  = I_Data;
                    state_nxt = FULL;
                end else if (consume) begin
                    main_nxt  = BUBBLE;
                    state_nxt = EMPTY;
                end
                FULL: if (consume) begin
                    main_nxt  = skid_data;
                    skid_nxt  = BUBBLE;
                    state_nxt = ONE;
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = BUBBLE;
                    skid_nxt  = BUBBLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks of pipe_stage_skid against a queue model.
module tb_pipe_stage_skid;
    localparam int W = 96;
    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         I_Valid = 1'b0;
    logic         I_Ready;
    logic [W-1:0] I_Data = '0;
    logic         Flush = 1'b0;
    logic         O_Valid;
    logic         O_Ready = 1'b0;
    logic [W-1:0] O_Data;
    logic [1:0]   Count;
    int tests = 0;
    int fails = 0;
    logic [W-1:0] q[$];

    pipe_stage_skid dut (
        .Clk(Clk), .Rst_n(Rst_n), .I_Valid(I_Valid), .I_Ready(I_Ready), .I_Data(I_Data),
        .Flush(Flush), .O_Valid(O_Valid), .O_Ready(O_Ready), .O_Data(O_Data), .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two entries; the stage offers the head.
    always @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) q.delete();
        else if (Flush) q.delete();
        else begin
            automatic bit acc = I_Valid && q.size() < 2;
            if (O_Ready && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(I_Data);
        end
    end

    always @(posedge Clk) begin
        chk("o_valid", W'(O_Valid), W'(q.size() > 0));
        chk("o_data", O_Data, q.size() > 0 ? q[0] : '0);
        chk("count", W'(Count), W'(q.size()));
        chk("i_ready", W'(I_Ready), W'(q.size() < 2));
        chk("count_max", W'(Count <= 2'd2), W'(1));
    end

    function automatic logic [W-1:0] pay(input int i);
        return {32'h4 + 32'(i) * 4, 32'h1000 + 32'(i) * 4, 32'hA000_0000 + 32'(i)};
    endfunction

    task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        I_Valid = iv;
        I_Data  = d;
        O_Ready = ordy;
        Flush   = fl;
        @(posedge Clk);
        #1;
    endtask

    task automatic lit(input string n, input logic v, input logic [W-1:0] d, input logic [1:0] c, input logic r);
        chk({n, "_valid"}, W'(O_Valid), W'(v));
        chk({n, "_data"}, O_Data, d);
        chk({n, "_count"}, W'(Count), W'(c));
        chk({n, "_ready"}, W'(I_Ready), W'(r));
    endtask

    initial begin
        @(posedge Clk);
        #1;
        lit("reset", 1'b0, '0, 2'd0, 1'b1);
        Rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, pay(i), 1'b1, 1'b0);
            lit("stream", 1'b1, pay(i), 2'd1, 1'b1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        lit("drain", 1'b0, '0, 2'd0, 1'b1);
        cyc(1'b1, pay(1), 1'b1, 1'b0);
        lit("stall_a1", 1'b1, pay(1), 2'd1, 1'b1);
        cyc(1'b1, pay(2), 1'b0, 1'b0);
        lit("stall_full", 1'b1, pay(1), 2'd2, 1'b0);
        cyc(1'b1, pay(3), 1'b0, 1'b0);
        lit("stall_hold", 1'b1, pay(1), 2'd2, 1'b0);
        cyc(1'b1, pay(3), 1'b1, 1'b0);
        lit("stall_a2", 1'b1, pay(2), 2'd1, 1'b1);
        cyc(1'b1, pay(3), 1'b1, 1'b0);
        lit("stall_a3", 1'b1, pay(3), 2'd1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, pay(1), 1'b0, 1'b0);
        cyc(1'b1, pay(2), 1'b0, 1'b0);
        lit("flush_pre", 1'b1, pay(1), 2'd2, 1'b0);
        cyc(1'b1, pay(3), 1'b1, 1'b1);
        lit("flush", 1'b0, '0, 2'd0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        lit("flush_after", 1'b0, '0, 2'd0, 1'b1);
        cyc(1'b1, pay(1), 1'b0, 1'b0);
        cyc(1'b1, pay(2), 1'b0, 1'b0);
        lit("rst_pre", 1'b1, pay(1), 2'd2, 1'b0);
        I_Valid = 1'b0;
        #1 Rst_n = 1'b0;
        #1 lit("rst_async", 1'b0, '0, 2'd0, 1'b1);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        cyc(1'b1, pay(9), 1'b1, 1'b0);
        lit("rst_a9", 1'b1, pay(9), 2'd1, 1'b1);
        for (int i = 0; i < 10000; i++)
            cyc(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                $urandom_range(0, 99) < 5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
